// File: rtl/ysyx_22050019_wbu_commit_if.sv
// rtl/ysyx_22050019_wbu_commit_if.sv - trace stream from write-back to difftest/trace consumer
interface ysyx_22050019_wbu_commit_if;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [63:0] trace_pc_o;
  logic [31:0] trace_inst_o;
  logic        trace_we_o;
  logic [4:0]  trace_rd_o;
  logic [63:0] trace_wdata_o;

  modport master (
    output trace_valid_o, trace_pc_o, trace_inst_o, trace_we_o, trace_rd_o, trace_wdata_o,
    input  trace_ready_i
  );

  modport slave (
    input  trace_valid_o, trace_pc_o, trace_inst_o, trace_we_o, trace_rd_o, trace_wdata_o,
    output trace_ready_i
  );
endinterface

// File: rtl/ysyx_22050019_wbu_commit.sv
// rtl/ysyx_22050019_wbu_commit.sv - write-back: 32x64 regfile with bypass, commit trace FIFO, instret
module ysyx_22050019_wbu_commit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [63:0] wb_wdata_i,
  input  logic        commit_i,
  input  logic [63:0] commit_pc_i,
  input  logic [31:0] commit_inst_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [63:0] rs1_data_o,
  output logic [63:0] rs2_data_o,
  output logic        stall_o,
  ysyx_22050019_wbu_commit_if.master trace,
  output logic [63:0] instret_o,
  output logic        overflow_o
);
  localparam int PTR_W = CNT_W - 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] wdata;
  } entry_t;

  logic [63:0] regs_q [32];
  logic [63:0] regs_d [32];
  entry_t      fifo_q [DEPTH];
  entry_t      fifo_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0] instret_q, instret_d;
  logic        overflow_q, overflow_d;

  logic   reg_wr, push, pop;
  entry_t head;

  assign reg_wr = wb_we_i && (wb_waddr_i != 5'd0);

  always_comb begin
    rs1_data_o = regs_q[rs1_addr_i];
    if (rs1_addr_i == 5'd0)                      rs1_data_o = 64'd0;
    else if (reg_wr && rs1_addr_i == wb_waddr_i) rs1_data_o = wb_wdata_i;
    rs2_data_o = regs_q[rs2_addr_i];
    if (rs2_addr_i == 5'd0)                      rs2_data_o = 64'd0;
    else if (reg_wr && rs2_addr_i == wb_waddr_i) rs2_data_o = wb_wdata_i;
  end

  always_comb begin
    regs_d = regs_q;
    if (reg_wr) regs_d[wb_waddr_i] = wb_wdata_i;

    pop  = (count_q != '0) && trace.trace_ready_i;
    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    push = commit_i && ((count_q != CNT_W'(DEPTH)) || pop);

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = '{pc: commit_pc_i, inst: commit_inst_i, we: reg_wr,
                                   rd: wb_waddr_i, wdata: wb_wdata_i};

    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    instret_d  = instret_q + 64'(push);
    overflow_d = overflow_q | (commit_i && !push);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q     <= '{default: '0};
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      instret_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      instret_q  <= instret_d;
      overflow_q <= overflow_d;
    end
  end

  // An empty FIFO presents an all-zero head.
  assign head = (count_q != '0) ? fifo_q[rd_ptr_q] : '0;

  assign trace.trace_valid_o = (count_q != '0);
  assign trace.trace_pc_o    = head.pc;
  assign trace.trace_inst_o  = head.inst;
  assign trace.trace_we_o    = head.we;
  assign trace.trace_rd_o    = head.rd;
  assign trace.trace_wdata_o = head.wdata;

  assign stall_o    = (count_q >= CNT_W'(DEPTH - 1));
  assign instret_o  = instret_q;
  assign overflow_o = overflow_q;
endmodule

// File: tb/tb_ysyx_22050019_wbu_commit.sv
// tb/tb_ysyx_22050019_wbu_commit.sv - self-checking bench for the write-back commit block
module tb_ysyx_22050019_wbu_commit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we_i;
  logic [4:0]  wb_waddr_i;
  logic [63:0] wb_wdata_i;
  logic        commit_i;
  logic [63:0] commit_pc_i;
  logic [31:0] commit_inst_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic [63:0] rs1_data_o, rs2_data_o;
  logic        stall_o;
  logic [63:0] instret_o;
  logic        overflow_o;

  ysyx_22050019_wbu_commit_if tif ();

  ysyx_22050019_wbu_commit #(.DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .commit_i(commit_i), .commit_pc_i(commit_pc_i), .commit_inst_i(commit_inst_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .stall_o(stall_o), .trace(tif),
    .instret_o(instret_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] wdata;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] mregs [32];
  logic [63:0] minstret;
  logic        movf;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [63:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (wb_we_i && a == wb_waddr_i) return wb_wdata_i;
    return mregs[a];
  endfunction

  // Advances one clock edge with the currently driven inputs and updates the model.
  task automatic step();
    bit   pop, push;
    ent_t e;
    pop  = (mq.size() != 0) && tif.trace_ready_i;
    push = commit_i && ((mq.size() < DEPTH) || pop);
    e.pc = commit_pc_i; e.inst = commit_inst_i; e.we = wb_we_i && (wb_waddr_i != 0);
    e.rd = wb_waddr_i;  e.wdata = wb_wdata_i;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      foreach (mregs[i]) mregs[i] = 64'd0;
      minstret = 64'd0;
      movf = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin mq.push_back(e); minstret = minstret + 64'd1; end
      if (commit_i && !push) movf = 1'b1;
      if (wb_we_i && wb_waddr_i != 0) mregs[wb_waddr_i] = wb_wdata_i;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb_we_i = 0; wb_waddr_i = 0; wb_wdata_i = 0;
    commit_i = 0; commit_pc_i = 0; commit_inst_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0; tif.trace_ready_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0; step(); rst_n = 1; #1;
  endtask

  task automatic test_reset();
    do_reset();
    rs1_addr_i = 5; #1;
    n_checks++; if (tif.trace_valid_o !== 1'b0) $display("FAIL reset_valid got %0b want 0", tif.trace_valid_o); else n_pass++;
    n_checks++; if (stall_o !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall_o); else n_pass++;
    n_checks++; if (instret_o !== 64'd0) $display("FAIL reset_instret got %0h want 0", instret_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow_o); else n_pass++;
    n_checks++; if ({tif.trace_pc_o, tif.trace_inst_o, tif.trace_wdata_o} !== '0) $display("FAIL reset_head got %0h want 0", tif.trace_pc_o); else n_pass++;
    n_checks++; if (rs1_data_o !== 64'd0) $display("FAIL reset_x5 got %0h want 0", rs1_data_o); else n_pass++;
    wb_we_i = 1; wb_waddr_i = 0; wb_wdata_i = 64'hFFFF; rs1_addr_i = 0; #1;
    n_checks++; if (rs1_data_o !== 64'd0) $display("FAIL x0_bypass got %0h want 0", rs1_data_o); else n_pass++;
    step(); wb_we_i = 0; #1;
    n_checks++; if (rs1_data_o !== 64'd0) $display("FAIL x0_store got %0h want 0", rs1_data_o); else n_pass++;
  endtask

  task automatic test_bypass();
    wb_we_i = 1; wb_waddr_i = 3; wb_wdata_i = 64'h1234; rs1_addr_i = 3; rs2_addr_i = 3; #1;
    n_checks++; if (rs1_data_o !== 64'h1234) $display("FAIL bypass_rs1 got %0h want 1234", rs1_data_o); else n_pass++;
    n_checks++; if (rs2_data_o !== 64'h1234) $display("FAIL bypass_rs2 got %0h want 1234", rs2_data_o); else n_pass++;
    step(); wb_we_i = 0; #1;
    n_checks++; if (rs1_data_o !== 64'h1234) $display("FAIL stored_rs1 got %0h want 1234", rs1_data_o); else n_pass++;
  endtask

  task automatic test_single_commit();
    tif.trace_ready_i = 1;
    commit_i = 1; commit_pc_i = 64'h8000_0000; commit_inst_i = 32'h0010_0093;
    wb_we_i = 1; wb_waddr_i = 1; wb_wdata_i = 64'd1;
    step();
    commit_i = 0; wb_we_i = 0; #1;
    n_checks++; if (tif.trace_valid_o !== 1'b1) $display("FAIL single_valid got %0b want 1", tif.trace_valid_o); else n_pass++;
    n_checks++; if ({tif.trace_pc_o, tif.trace_inst_o, tif.trace_we_o, tif.trace_rd_o, tif.trace_wdata_o}
                    !== {64'h8000_0000, 32'h0010_0093, 1'b1, 5'd1, 64'd1})
      $display("FAIL single_fields got pc=%0h inst=%0h we=%0b rd=%0d wd=%0h want pc=80000000 inst=100093 we=1 rd=1 wd=1",
               tif.trace_pc_o, tif.trace_inst_o, tif.trace_we_o, tif.trace_rd_o, tif.trace_wdata_o);
    else n_pass++;
    n_checks++; if (instret_o !== 64'd1) $display("FAIL single_instret got %0d want 1", instret_o); else n_pass++;
    step();
    n_checks++; if (tif.trace_valid_o !== 1'b0) $display("FAIL single_drained got %0b want 0", tif.trace_valid_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      commit_i = 1; commit_pc_i = 64'h1000 + 64'(i * 4); commit_inst_i = 32'(i);
      wb_we_i = (i == 4); wb_waddr_i = 7; wb_wdata_i = 64'hABCD;
      step();
      n_checks++; if (stall_o !== (i >= 2)) $display("FAIL bp_stall_%0d got %0b want %0b", i, stall_o, i >= 2); else n_pass++;
      n_checks++; if (overflow_o !== (i == 4)) $display("FAIL bp_overflow_%0d got %0b want %0b", i, overflow_o, i == 4); else n_pass++;
    end
    commit_i = 0; wb_we_i = 0; rs1_addr_i = 7; #1;
    n_checks++; if (instret_o !== 64'd4) $display("FAIL bp_instret got %0d want 4", instret_o); else n_pass++;
    n_checks++; if (rs1_data_o !== 64'hABCD) $display("FAIL bp_regwrite got %0h want abcd", rs1_data_o); else n_pass++;
    tif.trace_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (tif.trace_pc_o !== 64'h1000 + 64'(i * 4)) $display("FAIL drain_pc_%0d got %0h want %0h", i, tif.trace_pc_o, 64'h1000 + 64'(i * 4)); else n_pass++;
      n_checks++; if (stall_o !== (i < 2)) $display("FAIL drain_stall_%0d got %0b want %0b", i, stall_o, i < 2); else n_pass++;
      step();
    end
    n_checks++; if (tif.trace_valid_o !== 1'b0) $display("FAIL drain_empty got %0b want 0", tif.trace_valid_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL overflow_sticky got %0b want 1", overflow_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      commit_i = 1; commit_pc_i = 64'h2000 + 64'(i); step();
    end
    tif.trace_ready_i = 1;
    for (int i = 4; i < 11; i++) begin
      commit_pc_i = 64'h2000 + 64'(i); #1;
      n_checks++; if (tif.trace_pc_o !== mq[0].pc) $display("FAIL b2b_head_%0d got %0h want %0h", i, tif.trace_pc_o, mq[0].pc); else n_pass++;
      n_checks++; if (stall_o !== 1'b1) $display("FAIL b2b_stall_%0d got %0b want 1", i, stall_o); else n_pass++;
      step();
      n_checks++; if (overflow_o !== 1'b0) $display("FAIL b2b_overflow_%0d got %0b want 0", i, overflow_o); else n_pass++;
    end
    n_checks++; if (instret_o !== 64'd11) $display("FAIL b2b_instret got %0d want 11", instret_o); else n_pass++;
    commit_i = 0; wb_we_i = 1; wb_waddr_i = 9; wb_wdata_i = 64'h55; step();
    rst_n = 0; wb_we_i = 0; step(); rst_n = 1; rs1_addr_i = 9; rs2_addr_i = 3; #1;
    n_checks++; if (tif.trace_valid_o !== 1'b0) $display("FAIL midrst_valid got %0b want 0", tif.trace_valid_o); else n_pass++;
    n_checks++; if (instret_o !== 64'd0) $display("FAIL midrst_instret got %0d want 0", instret_o); else n_pass++;
    n_checks++; if (stall_o !== 1'b0) $display("FAIL midrst_stall got %0b want 0", stall_o); else n_pass++;
    n_checks++; if ({rs1_data_o, rs2_data_o} !== 128'd0) $display("FAIL midrst_regs got %0h/%0h want 0", rs1_data_o, rs2_data_o); else n_pass++;
  endtask

  task automatic test_random();
    ent_t h;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      wb_we_i = $urandom_range(0, 1); wb_waddr_i = 5'($urandom_range(0, 7));
      wb_wdata_i = {$urandom, $urandom};
      commit_i = ($urandom_range(0, 9) < 6); commit_pc_i = {$urandom, $urandom}; commit_inst_i = $urandom;
      rs1_addr_i = 5'($urandom_range(0, 7)); rs2_addr_i = 5'($urandom_range(0, 7));
      tif.trace_ready_i = ($urandom_range(0, 9) < 4);
      #1;
      if (mq.size() != 0) h = mq[0];
      else begin h.pc = 0; h.inst = 0; h.we = 0; h.rd = 0; h.wdata = 0; end
      n_checks++; if (rs1_data_o !== ref_read(rs1_addr_i)) $display("FAIL rnd_rs1 c=%0d got %0h want %0h", c, rs1_data_o, ref_read(rs1_addr_i)); else n_pass++;
      n_checks++; if (rs2_data_o !== ref_read(rs2_addr_i)) $display("FAIL rnd_rs2 c=%0d got %0h want %0h", c, rs2_data_o, ref_read(rs2_addr_i)); else n_pass++;
      n_checks++; if (tif.trace_valid_o !== (mq.size() != 0)) $display("FAIL rnd_valid c=%0d got %0b want %0b", c, tif.trace_valid_o, mq.size() != 0); else n_pass++;
      n_checks++; if (stall_o !== (mq.size() >= DEPTH - 1)) $display("FAIL rnd_stall c=%0d got %0b want %0b", c, stall_o, mq.size() >= DEPTH - 1); else n_pass++;
      n_checks++; if (instret_o !== minstret) $display("FAIL rnd_instret c=%0d got %0d want %0d", c, instret_o, minstret); else n_pass++;
      n_checks++; if (overflow_o !== movf) $display("FAIL rnd_overflow c=%0d got %0b want %0b", c, overflow_o, movf); else n_pass++;
      n_checks++; if ({tif.trace_pc_o, tif.trace_inst_o, tif.trace_we_o, tif.trace_rd_o, tif.trace_wdata_o}
                      !== {h.pc, h.inst, h.we, h.rd, h.wdata})
        $display("FAIL rnd_head c=%0d got pc=%0h rd=%0d wd=%0h want pc=%0h rd=%0d wd=%0h", c,
                 tif.trace_pc_o, tif.trace_rd_o, tif.trace_wdata_o, h.pc, h.rd, h.wdata);
      else n_pass++;
      step();
    end
  endtask

  initial begin
    foreach (mregs[i]) mregs[i] = 64'd0;
    minstret = 64'd0;
    movf = 1'b0;
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_bypass();
    test_single_commit();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ysyx_22050019_wbu_commit.md
Name: ysyx_22050019_wbu_commit

Overview:
Write-back end of the MEM/WB stage. It consumes the MEM/WB outputs: register write enable, address and data, plus the commit flag with its PC and instruction. It owns the 32x64 integer register file, with two read ports and same-cycle write bypass. Each committed instruction is buffered in a small trace FIFO that drains to the difftest/trace consumer over valid/ready. When the FIFO nears full, the block back-pressures MEM/WB through stall_o, which drives mem_wb_stall_i.

Parameters:
DEPTH, 4, trace FIFO entries; power of two, >=2
CNT_W, 3, FIFO occupancy counter width; must equal log2(DEPTH)+1

Ports:
clk  in  1  single clock; all state updates on posedge
rst_n  in  1  synchronous reset, active-low (state reset when rst_n==0 at posedge)
wb_we_i  in  1  register write enable from MEM/WB
wb_waddr_i  in  5  destination register
wb_wdata_i  in  64  write data
commit_i  in  1  one instruction retires this cycle
commit_pc_i  in  64  PC of retiring instruction
commit_inst_i  in  32  encoding of retiring instruction
rs1_addr_i  in  5  read port 1 address (decode stage)
rs2_addr_i  in  5  read port 2 address
rs1_data_o  out  64  read port 1 data (combinational)
rs2_data_o  out  64  read port 2 data (combinational)
stall_o  out  1  back-pressure to MEM/WB (mem_wb_stall_i)
trace_valid_o  out  1  FIFO head valid
trace_ready_i  in  1  consumer accepts head
trace_pc_o  out  64  head PC
trace_inst_o  out  32  head instruction
trace_we_o  out  1  head wrote a register
trace_rd_o  out  5  head destination
trace_wdata_o  out  64  head write data
instret_o  out  64  count of accepted commits
overflow_o  out  1  sticky: commit arrived while FIFO full

Behaviour:
- Reset (rst_n==0 at posedge): all 32 registers <=0; FIFO empty (rd/wr pointers 0, count 0); instret_o=0; overflow_o=0. Therefore trace_valid_o=0, stall_o=0, and trace_* data outputs=0 (empty head reads as zero). Reset mid-drain discards all entries; no partial handshake survives.
- Register file:
  - Write at posedge when wb_we_i && wb_waddr_i!=0. The write is independent of commit_i and FIFO state; it is never blocked.
  - x0 always reads 0; writes to x0 are ignored.
  - Read is combinational. If rsN_addr_i==wb_waddr_i, wb_we_i==1 and the address !=0, rsN_data_o=wb_wdata_i (bypass). Otherwise it returns the stored value.
- Push: push = commit_i && (count<DEPTH || pop).
  - Entry = {commit_pc_i, commit_inst_i, wb_we_i && wb_waddr_i!=0, wb_waddr_i, wb_wdata_i}.
  - For non-writing commits, rd and wdata are stored as presented; the consumer ignores them.
- Pop: pop = trace_valid_o && trace_ready_i.
  - Head data is stable while trace_valid_o=1 and trace_ready_i=0.
  - trace_valid_o = (count!=0).
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at full and at count 1.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- stall_o = (count >= DEPTH-1), combinational from registered count. This gives one cycle of margin, since MEM/WB's commit output is registered.
- Overflow: if commit_i && count==DEPTH && !pop, the commit is dropped from the trace and overflow_o<=1 (sticky until reset). The register write still occurs and instret does not increment.
- instret_o increments by 1 on every push and wraps at 2^64.
- Latency:
  - commit_i at edge N is visible on trace_valid_o/trace_* after edge N if the FIFO was empty.
  - A register write at edge N is visible through storage from edge N, and through bypass in the same cycle.

Test Plan:
- Reset then idle: all outputs 0; rs1_addr_i=5 returns 0; a write to x0 with data 0xFFFF then reading x0 returns 0.
- Bypass: wb_we_i=1, waddr=3, wdata=0x1234, rs1_addr_i=3 in the same cycle -> rs1_data_o=0x1234 before the edge. After the edge with wb_we_i=0, rs1_data_o=0x1234 from storage.
- Single commit, ready=1: commit_i=1, pc=0x80000000, inst=0x00100093, we=1, rd=1, wdata=1 -> next cycle trace_valid_o=1 with exactly those fields; popped that cycle; instret_o=1; valid=0 afterwards.
- Back-pressure, DEPTH=4, trace_ready_i=0: three commits -> stall_o=1 after the third (count 3). A fourth commit -> count 4, stall_o=1, overflow_o=0. Drain with ready=1 -> entries emerge in order, stall_o drops when count reaches 2.
- Overflow: with count=4 and ready=0, a fifth commit -> overflow_o=1, count stays 4, instret_o=4, register write still performed.
- Simultaneous push/pop at full plus mid-operation reset: count stays 4 and the pointers wrap correctly. Then rst_n=0 for one edge -> trace_valid_o=0, count=0, instret_o=0, and all registers read 0.
